// File: rtl/btb_assoc_predictor.sv
// btb_assoc_predictor
//   Set-associative branch target buffer. Each entry holds a tag, a target and
//   a saturating direction counter. Replacement is round-robin within a set.
//   There is also a global flush.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   lookup_pc         fetch PC from IF. The lookup is combinational from the
//                     stored state.
//   pred_hit          a valid way in the indexed set matches the tag
//   pred_taken        pred_hit AND the MSB of the counter
//   pred_target       target of the hit entry; 0 on a miss
//   pred_state        counter of the hit entry; 0 on a miss
//   update_valid      EX resolved a branch this cycle
//   update_pc         PC of the resolved branch
//   update_taken      actual direction of the resolved branch
//   update_target     actual target of the resolved branch
//   flush             invalidate all entries and reset the replacement pointers
module btb_assoc_predictor #(
  parameter int XLEN     = 32,
  parameter int SETS     = 16,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic [CTR_BITS-1:0] pred_state,
  input  logic                update_valid,
  input  logic [XLEN-1:0]     update_pc,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic                flush
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = XLEN - IDX - 2;
  // A single-way BTB still gets a 1-bit pointer. That pointer is held at zero.
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic                valid_q  [SETS][WAYS];
  logic [TAGW-1:0]     tag_q    [SETS][WAYS];
  logic [XLEN-1:0]     target_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
  logic [WW-1:0]       rr_q     [SETS];

  logic [IDX-1:0]  l_idx;
  logic [TAGW-1:0] l_tag;
  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;

  assign l_idx = lookup_pc[IDX+1:2];
  assign l_tag = lookup_pc[XLEN-1:IDX+2];
  assign u_idx = update_pc[IDX+1:2];
  assign u_tag = update_pc[XLEN-1:IDX+2];

  // The byte-offset bits of both PCs never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup. A tag is never allocated twice in one set, so at most one way can match.
  always_comb begin
    pred_hit    = 1'b0;
    pred_target = '0;
    pred_state  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
        pred_hit    = 1'b1;
        pred_target = target_q[l_idx][w];
        pred_state  = ctr_q[l_idx][w];
      end
    end
  end

  // On a miss pred_state is 0, so its MSB alone is a safe taken indication.
  assign pred_taken = pred_hit & pred_state[CTR_BITS-1];

  logic          u_hit;
  logic [WW-1:0] u_hit_way;
  logic          u_free;
  logic [WW-1:0] u_free_way;
  logic [WW-1:0] u_victim;

  // Update-side search. The loop scans downward so that the lowest-numbered
  // invalid way is the one left in u_free_way.
  always_comb begin
    u_hit      = 1'b0;
    u_hit_way  = '0;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[u_idx][w]) begin
        u_free     = 1'b1;
        u_free_way = WW'(w);
      end
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = WW'(w);
      end
    end
  end

  assign u_victim = u_free ? u_free_way : rr_q[u_idx];

  // State update. Priority is reset, then flush, then update. A flush clears
  // only the valid bits and the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else if (update_valid) begin
      if (u_hit) begin
        if (update_taken) begin
          if (ctr_q[u_idx][u_hit_way] != CTR_MAX) begin
            ctr_q[u_idx][u_hit_way] <= ctr_q[u_idx][u_hit_way] + 1'b1;
          end
          target_q[u_idx][u_hit_way] <= update_target;
        end else if (ctr_q[u_idx][u_hit_way] != '0) begin
          ctr_q[u_idx][u_hit_way] <= ctr_q[u_idx][u_hit_way] - 1'b1;
        end
      end else if (update_taken) begin
        valid_q[u_idx][u_victim]  <= 1'b1;
        tag_q[u_idx][u_victim]    <= u_tag;
        target_q[u_idx][u_victim] <= update_target;
        ctr_q[u_idx][u_victim]    <= CTR_WEAK;
        // The pointer advances only when it chose the victim. The WW-bit add
        // wraps naturally because WAYS is a power of two.
        if (!u_free && (WAYS > 1)) begin
          rr_q[u_idx] <= rr_q[u_idx] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// tb_btb_assoc_predictor
//   Self-checking bench for btb_assoc_predictor with the default parameters
//   (XLEN=32, SETS=16, WAYS=2, CTR_BITS=2).
//
//   A behavioural model follows the BTB. For each set it holds a list of
//   (valid, tag, target, counter) slots and a replacement pointer. A compare
//   process checks every lookup against that model.
//
//   Directed scenarios pin both the DUT and the model to hand-computed values.
//   A randomized phase follows the directed scenarios.
module tb_btb_assoc_predictor;

  localparam int XLEN     = 32;
  localparam int SETS     = 16;
  localparam int WAYS     = 2;
  localparam int CTR_BITS = 2;
  localparam int CTR_MAX  = (1 << CTR_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [XLEN-1:0]     lookup_pc = '0;
  logic                pred_hit;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic [CTR_BITS-1:0] pred_state;
  logic                update_valid = 1'b0;
  logic [XLEN-1:0]     update_pc = '0;
  logic                update_taken = 1'b0;
  logic [XLEN-1:0]     update_target = '0;
  logic                flush = 1'b0;

  int errors = 0;
  int checks = 0;
  bit model_ready = 1'b0;

  always #5 clk = ~clk;

  btb_assoc_predictor #(
    .XLEN(XLEN), .SETS(SETS), .WAYS(WAYS), .CTR_BITS(CTR_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .pred_state(pred_state),
    .update_valid(update_valid),
    .update_pc(update_pc),
    .update_taken(update_taken),
    .update_target(update_target),
    .flush(flush)
  );

  // Behavioural model. The set is the PC word address modulo SETS, and the tag
  // is whatever lies above it.
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned tgt;
    int          ctr;
  } ent_t;

  ent_t m_ent [SETS][WAYS];
  int   m_rr  [SETS];

  function automatic int setOf(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int unsigned tagOf(input logic [XLEN-1:0] pc);
    return pc / (4 * SETS);
  endfunction

  function automatic void modelLookup(input logic [XLEN-1:0] pc, output bit hit,
                                      output int unsigned tgt, output int st);
    int s;
    s   = setOf(pc);
    hit = 1'b0;
    tgt = 0;
    st  = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_ent[s][w].v && m_ent[s][w].tag == tagOf(pc)) begin
        hit = 1'b1;
        tgt = m_ent[s][w].tgt;
        st  = m_ent[s][w].ctr;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < WAYS; w++) m_ent[s][w] = '{1'b0, 0, 0, 0};
      end
      model_ready = 1'b1;
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < WAYS; w++) m_ent[s][w].v = 1'b0;
      end
    end else if (update_valid) begin
      int s;
      int hw;
      int victim;
      s  = setOf(update_pc);
      hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_ent[s][w].v && m_ent[s][w].tag == tagOf(update_pc)) hw = w;
      if (hw >= 0) begin
        if (update_taken) begin
          m_ent[s][hw].ctr = (m_ent[s][hw].ctr < CTR_MAX) ? m_ent[s][hw].ctr + 1 : CTR_MAX;
          m_ent[s][hw].tgt = update_target;
        end else begin
          m_ent[s][hw].ctr = (m_ent[s][hw].ctr > 0) ? m_ent[s][hw].ctr - 1 : 0;
        end
      end else if (update_taken) begin
        victim = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_ent[s][w].v) victim = w;
        if (victim < 0) begin
          victim  = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_ent[s][victim] = '{1'b1, tagOf(update_pc), update_target, 1 << (CTR_BITS - 1)};
      end
    end
  end

  // Compare process: on every falling edge after the first reset edge.
  always @(negedge clk) begin
    if (model_ready) begin
      bit          eh;
      int unsigned et;
      int          es;
      modelLookup(lookup_pc, eh, et, es);
      checks++;
      if (pred_hit !== eh || pred_taken !== (eh && es >= (1 << (CTR_BITS - 1))) ||
          pred_target !== et || pred_state !== CTR_BITS'(es)) begin
        errors++;
        $display("[TB] FAIL model_cmp pc=%h got hit=%0b taken=%0b tgt=%h st=%0d exp hit=%0b tgt=%h st=%0d",
                 lookup_pc, pred_hit, pred_taken, pred_target, pred_state, eh, et, es);
      end
    end
  end

  task automatic applyStimulus(input logic uv, input logic [XLEN-1:0] upc, input logic ut,
                               input logic [XLEN-1:0] utgt, input logic fl, input logic rs,
                               input logic [XLEN-1:0] lpc);
    @(posedge clk);
    #1;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    flush         = fl;
    rst           = rs;
    lookup_pc     = lpc;
  endtask

  // Compare both the DUT and the model against hand-computed values.
  task automatic checkOutput(input string name, input logic eh, input logic etk,
                             input logic [XLEN-1:0] et, input int es);
    bit          mh;
    int unsigned mt;
    int          ms;
    @(negedge clk);
    checks++;
    if (pred_hit !== eh || pred_taken !== etk || pred_target !== et || pred_state !== CTR_BITS'(es)) begin
      errors++;
      $display("[TB] FAIL %s got hit=%0b taken=%0b tgt=%h st=%0d exp hit=%0b taken=%0b tgt=%h st=%0d",
               name, pred_hit, pred_taken, pred_target, pred_state, eh, etk, et, es);
    end
    modelLookup(lookup_pc, mh, mt, ms);
    checks++;
    if (mh !== eh || mt !== et || ms !== es) begin
      errors++;
      $display("[TB] FAIL model_pin_%s got hit=%0b tgt=%h st=%0d exp hit=%0b tgt=%h st=%0d",
               name, mh, mt, ms, eh, et, es);
    end
  endtask

  task automatic doUpdate(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
    applyStimulus(1'b1, pc, tk, tgt, 1'b0, 1'b0, pc);
  endtask

  task automatic idleLookup(input logic [XLEN-1:0] pc);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, pc);
  endtask

  initial begin
    int exp_nt [3];
    int exp_tk [4];
    exp_nt = '{1, 0, 0};
    exp_tk = '{1, 2, 3, 3};

    // The BTB reads as all-zero once reset has been seen.
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h100);
    checkOutput("reset_state", 1'b0, 1'b0, '0, 0);
    idleLookup(32'h100);
    checkOutput("release_miss", 1'b0, 1'b0, '0, 0);

    // First allocation. There is no bypass within the same cycle.
    doUpdate(32'h100, 1'b1, 32'h200);
    checkOutput("no_bypass", 1'b0, 1'b0, '0, 0);
    idleLookup(32'h100);
    checkOutput("alloc_hit", 1'b1, 1'b1, 32'h200, 2);

    // Saturate the counter down, then up. Not-taken updates keep the target.
    for (int i = 0; i < 3; i++) begin
      doUpdate(32'h100, 1'b0, 32'hDEAD0000);
      idleLookup(32'h100);
      checkOutput("ctr_down", 1'b1, 1'b0, 32'h200, exp_nt[i]);
    end
    for (int i = 0; i < 4; i++) begin
      doUpdate(32'h100, 1'b1, 32'h200);
      idleLookup(32'h100);
      checkOutput("ctr_up", 1'b1, exp_tk[i] >= 2, 32'h200, exp_tk[i]);
    end

    // A not-taken miss does not allocate.
    doUpdate(32'h300, 1'b0, 32'h999);
    idleLookup(32'h300);
    checkOutput("nt_miss_no_alloc", 1'b0, 1'b0, '0, 0);

    // Conflict in set 0: way1 is filled first, then round-robin evicts way0.
    doUpdate(32'h140, 1'b1, 32'h1400);
    doUpdate(32'h180, 1'b1, 32'h1800);
    idleLookup(32'h100);
    checkOutput("evict_0x100", 1'b0, 1'b0, '0, 0);
    idleLookup(32'h140);
    checkOutput("keep_0x140", 1'b1, 1'b1, 32'h1400, 2);
    idleLookup(32'h180);
    checkOutput("keep_0x180", 1'b1, 1'b1, 32'h1800, 2);

    // A flush wins over a same-cycle update.
    applyStimulus(1'b1, 32'h500, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h500);
    idleLookup(32'h500);
    checkOutput("flush_drops_update", 1'b0, 1'b0, '0, 0);
    idleLookup(32'h140);
    checkOutput("flush_clears", 1'b0, 1'b0, '0, 0);

    // Advance rr to 1. Then reset with a pending update; the update is lost.
    doUpdate(32'h100, 1'b1, 32'h1000);
    doUpdate(32'h140, 1'b1, 32'h1400);
    doUpdate(32'h180, 1'b1, 32'h1800);
    applyStimulus(1'b1, 32'h600, 1'b1, 32'h6000, 1'b0, 1'b1, 32'h180);
    idleLookup(32'h180);
    checkOutput("reset_clears", 1'b0, 1'b0, '0, 0);
    idleLookup(32'h600);
    checkOutput("reset_drops_update", 1'b0, 1'b0, '0, 0);

    // Because reset returned rr to 0, the third allocation evicts way0 (0x140).
    doUpdate(32'h140, 1'b1, 32'h1400);
    doUpdate(32'h180, 1'b1, 32'h1800);
    doUpdate(32'h100, 1'b1, 32'h1000);
    idleLookup(32'h140);
    checkOutput("rr_reset_evict", 1'b0, 1'b0, '0, 0);
    idleLookup(32'h100);
    checkOutput("rr_reset_new", 1'b1, 1'b1, 32'h1000, 2);
    idleLookup(32'h180);
    checkOutput("rr_reset_keep", 1'b1, 1'b1, 32'h1800, 2);

    // Randomized traffic on a small pool of PCs, so that hits and evictions
    // both occur often.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [XLEN-1:0] upc;
      logic [XLEN-1:0] lpc;
      r   = $urandom_range(0, 255);
      upc = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      lpc = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0,
                    $urandom & 32'hFFFF_FFFC, (r >= 1 && r <= 2), (r == 0), lpc);
    end

    idleLookup(32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_assoc_predictor.md
Name: btb_assoc_predictor

Overview:
- Parametrised, set-associative branch target buffer (BTB) with per-entry saturating direction counters.
- Successor to the fixed single-entry-format BTB in the pipeline top; adds configurable sets, ways, counter width and round-robin replacement, plus a global flush.
- Lookup port is driven by IF and returns the prediction that IF/ID carries forward (bp_state). The update port is driven by EX on branch resolution.

Parameters:
XLEN, 32, address/target width
SETS, 16, number of sets; power of 2, >=2
WAYS, 2, associativity; 1, 2 or 4
CTR_BITS, 2, direction counter width; >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lookup_pc  in  XLEN  fetch PC from IF
pred_hit  out  1  tag match in a valid way
pred_taken  out  1  pred_hit AND counter MSB
pred_target  out  XLEN  target of hit entry; 0 on miss
pred_state  out  CTR_BITS  counter of hit entry; 0 on miss
update_valid  in  1  EX resolved a branch this cycle
update_pc  in  XLEN  PC of resolved branch
update_taken  in  1  actual direction
update_target  in  XLEN  actual target
flush  in  1  invalidate all entries

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Address fields: IDX = log2(SETS). Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2] (25 bits at XLEN=32, SETS=32). pc[1:0] is ignored.
- Entry contents: valid, tag, target, ctr[CTR_BITS-1:0]. Each set also holds a round-robin pointer rr of log2(WAYS) bits (absent when WAYS=1).
- Reset: all valid=0, rr=0, ctr=0, tag=0, target=0. Outputs therefore read pred_hit=0, pred_taken=0, pred_target=0, pred_state=0 from the first cycle rst is seen high.
- Lookup timing: combinational from registered state, zero latency.
- Lookup result: a hit returns the matching way's target and ctr. On a miss all outputs are 0.
- Lookup/update ordering: there is no bypass. An update at edge N is visible to lookup from cycle N+1.
- Update on hit (update_valid=1, valid tag match in the set):
  - taken: ctr saturating +1 (max 2^CTR_BITS-1); target <= update_target.
  - not taken: ctr saturating -1 (min 0); target unchanged.
  - rr unchanged.
- Update on miss, taken: allocate a way.
  - Victim is the lowest-numbered invalid way; if all ways are valid, the victim is way rr.
  - rr <= rr+1 (mod WAYS) only when the victim was chosen by rr.
  - Victim is written with valid=1, the tag, update_target, and ctr = 2^(CTR_BITS-1) (weakly taken).
- Update on miss, not taken: no state change.
- Tag uniqueness: allocation happens only on a miss, so a tag never occupies two ways of a set.
- flush=1: all valid <= 0 and all rr <= 0 at the next edge. flush has priority over a same-cycle update, which is discarded. Targets and counters need not be cleared.
- rst has priority over flush and update.
- Reset mid-operation: the state equals the post-reset state on the edge after rst is sampled high. Any pending update is lost.
- update_valid=0: no state change, regardless of the other update inputs.

Test Plan:
1. Release reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, pred_state=0.
2. Update pc=0x100, taken, target=0x200. Next-cycle lookup 0x100 -> pred_hit=1, pred_taken=1, pred_target=0x200, pred_state=2. Same-cycle lookup still misses (no bypass).
3. Counter saturation on pc=0x100:
   - Three not-taken updates -> pred_state 1, then 0, then 0; pred_taken=0 throughout.
   - Then four taken updates -> pred_state 1, 2, 3, 3.
4. Not-taken update on miss for pc=0x300 -> lookup 0x300 still pred_hit=0.
5. Conflict eviction (SETS=16, WAYS=2): taken updates to 0x100, 0x140, 0x180 (all index 0).
   - Third allocation evicts way0 (rr=0 -> 1).
   - Lookup 0x100 misses; 0x140 and 0x180 hit with their targets.
6. flush with a simultaneous taken update to 0x500 -> next cycle every lookup misses, including 0x500. Then assert rst mid-stream after new allocations -> all lookups miss and rr=0.
